// File: rtl/fire2_pkg.sv
// Shared types for the fire2 squeeze output buffer: channel vector layout and FSM states.
package fire2_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CH    = 16;
    localparam int unsigned CHW   = $clog2(CH);

    // Element [0] sits in the LSBs, matching the RAM word layout.
    typedef logic [CH-1:0][WIDTH-1:0] ch_vec_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ACK   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/fire2_squeeze_ofm_buf_if.sv
// Sample/ofm/ram_feedback capture side plus the serial ifm stream side of the buffer.
interface fire2_squeeze_ofm_buf_if;
    import fire2_pkg::*;

    logic               sample_i;
    ch_vec_t            ofm_i;
    logic               ram_feedback_o;
    logic               rd_en_i;
    logic [WIDTH-1:0]   ifm_o;
    logic               ifm_valid_o;
    logic               rd_done_o;
    logic               err_ovf_o;

    modport master (
        output sample_i, ofm_i, rd_en_i,
        input  ram_feedback_o, ifm_o, ifm_valid_o, rd_done_o, err_ovf_o
    );

    modport slave (
        input  sample_i, ofm_i, rd_en_i,
        output ram_feedback_o, ifm_o, ifm_valid_o, rd_done_o, err_ovf_o
    );

endinterface

// File: rtl/fmap_ram_sp.sv
// Simple-dual-port feature-map RAM: one write port, one registered read port.
module fmap_ram_sp #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned DW    = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [DW-1:0]   i_wdata,
    input  logic            i_re,
    input  logic [AW-1:0]   i_raddr,
    output logic [DW-1:0]   o_rdata
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/fire2_squeeze_ofm_buf.sv
// Stores one WOUT x WOUT frame of channel vectors, acknowledges it, then replays it
// as a pixel-major, channel-minor serial stream with a fixed two-cycle read latency.
module fire2_squeeze_ofm_buf
    import fire2_pkg::*;
#(
    parameter int unsigned WOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    fire2_squeeze_ofm_buf_if.slave      bus
);

    localparam int unsigned DEPTH = WOUT * WOUT;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned WW    = CH * WIDTH;
    localparam logic [AW-1:0]  LAST_PIX = AW'(DEPTH - 1);
    localparam logic [CHW-1:0] LAST_CH  = CHW'(CH - 1);

    state_t             r_state, w_state_nxt;
    logic [AW-1:0]      r_wr_ptr, w_wr_ptr_nxt;
    logic [AW-1:0]      r_rd_pix, w_rd_pix_nxt;
    logic [CHW-1:0]     r_rd_ch, w_rd_ch_nxt;
    logic               w_we, w_rd_req, w_last_req, w_fb_nxt, w_err_nxt;

    logic               r_v1, r_last1;
    logic [CHW-1:0]     r_ch1;
    logic [WW-1:0]      w_rdata;
    ch_vec_t            w_rvec;

    logic               r_fb, r_ifm_valid, r_rd_done, r_err;
    logic [WIDTH-1:0]   r_ifm;

    fmap_ram_sp #(
        .DEPTH (DEPTH),
        .DW    (WW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.ofm_i),
        .i_re    (w_rd_req),
        .i_raddr (r_rd_pix),
        .o_rdata (w_rdata)
    );

    assign w_rvec = ch_vec_t'(w_rdata);

    // Next-state, pointer advance and per-cycle strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_pix_nxt = r_rd_pix;
        w_rd_ch_nxt  = r_rd_ch;
        w_we         = 1'b0;
        w_rd_req     = 1'b0;
        w_last_req   = 1'b0;
        w_fb_nxt     = 1'b0;
        w_err_nxt    = r_err;

        case (r_state)
            ST_FILL: begin
                if (bus.sample_i) begin
                    w_we = 1'b1;
                    if (r_wr_ptr == LAST_PIX) begin
                        w_wr_ptr_nxt = '0;
                        w_fb_nxt     = 1'b1;
                        w_state_nxt  = ST_ACK;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                    end
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.rd_en_i) begin
                    w_rd_req = 1'b1;
                    if (r_rd_ch == LAST_CH) begin
                        w_rd_ch_nxt = '0;
                        if (r_rd_pix == LAST_PIX) begin
                            w_rd_pix_nxt = '0;
                            w_last_req   = 1'b1;
                            w_state_nxt  = ST_FLUSH;
                        end else begin
                            w_rd_pix_nxt = r_rd_pix + AW'(1);
                        end
                    end else begin
                        w_rd_ch_nxt = r_rd_ch + CHW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (r_rd_done) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase

        if (bus.sample_i && (r_state != ST_FILL)) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_wr_ptr    <= '0;
            r_rd_pix    <= '0;
            r_rd_ch     <= '0;
            r_v1        <= 1'b0;
            r_last1     <= 1'b0;
            r_ch1       <= '0;
            r_fb        <= 1'b0;
            r_ifm       <= '0;
            r_ifm_valid <= 1'b0;
            r_rd_done   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_pix    <= w_rd_pix_nxt;
            r_rd_ch     <= w_rd_ch_nxt;
            r_v1        <= w_rd_req;
            r_last1     <= w_last_req;
            r_ch1       <= r_rd_ch;
            r_fb        <= w_fb_nxt;
            r_ifm_valid <= r_v1;
            r_rd_done   <= r_v1 && r_last1;
            r_err       <= w_err_nxt;
            // Second pipeline stage: pick the requested channel out of the RAM word.
            if (r_v1) begin
                r_ifm <= w_rvec[r_ch1];
            end
        end
    end

    assign bus.ram_feedback_o = r_fb;
    assign bus.ifm_o          = r_ifm;
    assign bus.ifm_valid_o    = r_ifm_valid;
    assign bus.rd_done_o      = r_rd_done;
    assign bus.err_ovf_o      = r_err;

endmodule
